sum_deserializer: RTL and testbench



---
 rtl/sum_deserializer.sv | 70 +++++++
 tb/tb_sum_deserializer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_deserializer.sv
// sum_deserializer: packs W-bit sum chunks, LSB chunk first, into one N-bit
// result word. The result is offered on a valid/ready handshake and re-arms
// once it has been taken.
module sum_deserializer #(
    parameter int N = 256,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] c_in,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum
);

    localparam int CC = N / W;
    localparam int CW = (CC > 1) ? $clog2(CC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CC - 1);

    typedef enum logic {
        COLLECT,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Collect/present FSM. Handshake flags are registered alongside the state,
    // so in_ready is always the complement of out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            cnt       <= '0;
            sum       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_valid) begin
                        sum <= {c_in, sum[N-1:W]};
                        if (cnt == CNT_LAST) begin
                            cnt       <= '0;
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= COLLECT;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= COLLECT;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_deserializer.sv
// Self-checking bench for sum_deserializer: randomized chunk streams are
// compared against a packed-word reference built directly from the chunk list.
module tb_sum_deserializer;

    localparam int N  = 256;
    localparam int W  = 4;
    localparam int CC = N / W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] c_in = '0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [N-1:0] sum;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [W-1:0] chunks[$];

    always #5 clk = ~clk;

    sum_deserializer #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .c_in      (c_in),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum)
    );

    // Reference: chunk k lands in result slice k.
    function automatic logic [N-1:0] pack_model();
        logic [N-1:0] r = '0;
        for (int k = 0; k < CC; k++) r[k*W +: W] = chunks[k];
        return r;
    endfunction

    function automatic logic [N-1:0] rand_word();
        logic [N-1:0] r;
        for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present the CC queued chunks (optionally with random bubbles); the block
    // is expected to be ready throughout collection.
    task automatic feed(input bit bubbles, output int lat, output int after,
                        output int early, output int rdy_bad, output bit timeout);
        int sent  = 0;
        int cyc   = 0;
        int first = -1;
        int last  = -1;
        lat = -1; after = -1; early = 0; rdy_bad = 0; timeout = 1'b0;
        while (sent < CC && cyc < 8 * CC) begin
            in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            c_in     = chunks[sent];
            if (in_ready !== 1'b1) rdy_bad++;
            if (out_valid !== 1'b0) early++;
            tick();
            cyc++;
            if (in_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
                sent++;
            end
        end
        in_valid = 1'b0;
        if (sent < CC) timeout = 1'b1;
        else begin
            for (int w = 0; w < 4 && lat < 0; w++) begin
                if (out_valid === 1'b1) begin
                    lat   = cyc - first + 1;
                    after = cyc - last;
                end else begin
                    tick();
                    cyc++;
                end
            end
            if (lat < 0) timeout = 1'b1;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; c_in = '1; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (sum !== '0) begin failures++; $display("FAIL reset_sum: got %h expected 0", sum); end
    endtask

    task automatic test_constant();
        int lat, after, early, rdy_bad; bit to;
        chunks.delete();
        for (int k = 0; k < CC; k++) chunks.push_back(4'h1);
        feed(1'b0, lat, after, early, rdy_bad, to);
        checks++;
        if (to || lat != CC) begin failures++; $display("FAIL const_latency: got %0d (timeout %0b) expected %0d", lat, to, CC); end
        checks++;
        if (early != 0 || rdy_bad != 0) begin failures++; $display("FAIL const_collect_flags: got early=%0d rdy_bad=%0d expected 0/0", early, rdy_bad); end
        checks++;
        if (sum !== pack_model()) begin failures++; $display("FAIL const_sum: got %h expected %h", sum, pack_model()); end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL const_done_in_ready: got %b expected 0", in_ready); end
        consume();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL const_rearm: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
    endtask

    task automatic test_ordering();
        int lat, after, early, rdy_bad; bit to;
        logic [N-1:0] lit;
        lit = {4{64'hFEDCBA9876543210}};
        chunks.delete();
        for (int k = 0; k < CC; k++) chunks.push_back(W'(k % 16));
        feed(1'b0, lat, after, early, rdy_bad, to);
        checks++;
        if (to || sum !== pack_model()) begin failures++; $display("FAIL order_sum: got %h expected %h", sum, pack_model()); end
        checks++;
        if (sum !== lit) begin failures++; $display("FAIL order_literal: got %h expected %h", sum, lit); end
        consume();
    endtask

    task automatic test_backpressure();
        int lat, after, early, rdy_bad; bit to;
        logic [N-1:0] exp;
        int bad_sum = 0, bad_rdy = 0, bad_vld = 0;
        chunks.delete();
        for (int k = 0; k < CC; k++) chunks.push_back(W'($urandom_range(0, 15)));
        feed(1'b0, lat, after, early, rdy_bad, to);
        exp = pack_model();
        checks++;
        if (to || sum !== exp) begin failures++; $display("FAIL bp_sum: got %h expected %h", sum, exp); end
        out_ready = 1'b0; in_valid = 1'b1; c_in = 4'hF;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sum !== exp) bad_sum++;
            if (in_ready !== 1'b0) bad_rdy++;
            if (out_valid !== 1'b1) bad_vld++;
        end
        checks++;
        if (bad_sum != 0) begin failures++; $display("FAIL bp_hold_sum: got %0d changed cycles expected 0", bad_sum); end
        checks++;
        if (bad_rdy != 0 || bad_vld != 0) begin failures++; $display("FAIL bp_hold_flags: got rdy_bad=%0d vld_bad=%0d expected 0/0", bad_rdy, bad_vld); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
        checks++;
        if (sum !== exp) begin failures++; $display("FAIL bp_exit_no_accept: got %h expected %h", sum, exp); end
    endtask

    task automatic test_bubbles_reset();
        int lat, after, early, rdy_bad; bit to;
        int acc = 0;
        int cyc = 0;
        bit t = 1'b1;
        logic [30*W-1:0] top_exp;
        for (int k = 0; k < 30; k++) top_exp[k*W +: W] = 4'h7;
        while (acc < 30 && cyc < 200) begin
            in_valid = t; c_in = 4'h7;
            tick();
            cyc++;
            if (t) acc++;
            t = ~t;
        end
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bub_partial_flags: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
        checks++;
        if (sum[N-1 -: 30*W] !== top_exp) begin failures++; $display("FAIL bub_partial_sum: got %h expected %h", sum[N-1 -: 30*W], top_exp); end
        rst = 1'b1; in_valid = 1'b1; c_in = 4'hF;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        checks++;
        if (sum !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bub_reset: got sum=%h out_valid=%b in_ready=%b expected 0/0/1", sum, out_valid, in_ready); end
        chunks.delete();
        for (int k = 0; k < CC; k++) chunks.push_back(4'h5);
        feed(1'b0, lat, after, early, rdy_bad, to);
        checks++;
        if (to || lat != CC || early != 0) begin failures++; $display("FAIL bub_after_reset_latency: got %0d early=%0d expected %0d", lat, early, CC); end
        checks++;
        if (sum !== pack_model()) begin failures++; $display("FAIL bub_after_reset_sum: got %h expected %h", sum, pack_model()); end
        consume();
    endtask

    task automatic test_random();
        int lat, after, early, rdy_bad; bit to;
        logic [N-1:0] exp;
        for (int it = 0; it < 4; it++) begin
            int hold = 0;
            chunks.delete();
            for (int k = 0; k < CC; k++) chunks.push_back(W'($urandom_range(0, 15)));
            exp = pack_model();
            feed(1'b1, lat, after, early, rdy_bad, to);
            checks++;
            if (to || after != 0 || early != 0 || rdy_bad != 0) begin failures++; $display("FAIL rand_handshake[%0d]: got after=%0d early=%0d rdy_bad=%0d to=%0b expected 0/0/0/0", it, after, early, rdy_bad, to); end
            checks++;
            if (sum !== exp) begin failures++; $display("FAIL rand_sum[%0d]: got %h expected %h", it, sum, exp); end
            for (int d = 0; d < int'($urandom_range(0, 5)); d++) begin
                in_valid = 1'($urandom_range(0, 1));
                tick();
                if (out_valid !== 1'b1 || sum !== exp) hold++;
            end
            in_valid = 1'b0;
            checks++;
            if (hold != 0) begin failures++; $display("FAIL rand_hold[%0d]: got %0d bad cycles expected 0", it, hold); end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] a0, b0, a1, b1, r0, r1, lit;
        logic [W-1:0] stream[$];
        int pulses[$];
        logic [N-1:0] seen[$];
        int idx = 0;
        int e = 0;
        bit acc;
        a0 = '1; b0 = '1; a1 = rand_word(); b1 = rand_word();
        r0 = a0 + b0;
        r1 = a1 + b1;
        lit = {{(CC-1){4'hF}}, 4'hE};
        for (int k = 0; k < CC; k++) stream.push_back(r0[k*W +: W]);
        for (int k = 0; k < CC; k++) stream.push_back(r1[k*W +: W]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        while (e < 4 * CC && pulses.size() < 2) begin
            in_valid = (idx < 2 * CC);
            c_in     = (idx < 2 * CC) ? stream[idx] : '0;
            acc      = in_valid && (in_ready === 1'b1);
            tick();
            e++;
            if (acc) idx++;
            if (out_valid === 1'b1) begin
                pulses.push_back(e);
                seen.push_back(sum);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (pulses.size() != 2) begin
            failures++; $display("FAIL b2b_pulses: got %0d pulses expected 2", pulses.size());
        end else begin
            checks++;
            if (pulses[0] != CC) begin failures++; $display("FAIL b2b_first_pulse: got edge %0d expected %0d", pulses[0], CC); end
            checks++;
            if (pulses[1] != 2 * CC + 1) begin failures++; $display("FAIL b2b_second_pulse: got edge %0d expected %0d", pulses[1], 2 * CC + 1); end
            checks++;
            if (seen[0] !== r0 || seen[0] !== lit) begin failures++; $display("FAIL b2b_first_sum: got %h expected %h", seen[0], lit); end
            checks++;
            if (seen[1] !== r1) begin failures++; $display("FAIL b2b_second_sum: got %h expected %h", seen[1], r1); end
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_ordering();
        test_backpressure();
        test_bubbles_reset();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
